arbitru_incarcare: RTL and testbench

ARBITRU_INCARCARE -- requirements
Module: arbitru_incarcare

---
 rtl/arbitru_incarcare_pkg.sv | 26 ++
 rtl/arbitru_incarcare_if.sv | 37 +++
 rtl/arbitru_incarcare_verif_timp.sv | 15 +
 rtl/arbitru_incarcare.sv | 155 +++++++++++++++
 tb/tb_arbitru_incarcare.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/arbitru_incarcare_pkg.sv
// Shared definitions for the time-load arbiter.
//   - FSM state enumeration
//   - time field widths and range limits
//   - requester identifiers (MANUAL=0, UART=1)
package arbitru_incarcare_pkg;

  localparam int unsigned ORE_W    = 5;
  localparam int unsigned MINUTE_W = 6;

  // Exclusive upper bounds of a legal time-of-day.
  localparam logic [ORE_W-1:0]    MAX_ORE    = 5'd24;
  localparam logic [MINUTE_W-1:0] MAX_MINUTE = 6'd60;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCapture = 2'd1,
    StLoad    = 2'd2,
    StGuard   = 2'd3
  } state_e;

  typedef enum logic {
    ReqManual = 1'b0,
    ReqUart   = 1'b1
  } req_id_e;

endpackage

// File: rtl/arbitru_incarcare_if.sv
// Bus between the two time-setting requesters, the arbiter and the time counter.
//   master : requester/counter side (drives req_* and proposed times, observes results)
//   slave  : arbiter side (samples requests, drives load/ack/err/busy and the time)
interface arbitru_incarcare_if
  import arbitru_incarcare_pkg::*;
;
  logic                req_manual;
  logic [ORE_W-1:0]    ore_manual;
  logic [MINUTE_W-1:0] minute_manual;
  logic                req_uart;
  logic [ORE_W-1:0]    ore_uart;
  logic [MINUTE_W-1:0] minute_uart;

  logic                load;
  logic [ORE_W-1:0]    ore_out;
  logic [MINUTE_W-1:0] minute_out;
  logic                ack_manual;
  logic                ack_uart;
  logic                err_manual;
  logic                err_uart;
  logic                busy;

  modport master (
    output req_manual, ore_manual, minute_manual,
    output req_uart, ore_uart, minute_uart,
    input  load, ore_out, minute_out,
    input  ack_manual, ack_uart, err_manual, err_uart, busy
  );

  modport slave (
    input  req_manual, ore_manual, minute_manual,
    input  req_uart, ore_uart, minute_uart,
    output load, ore_out, minute_out,
    output ack_manual, ack_uart, err_manual, err_uart, busy
  );

endinterface

// File: rtl/arbitru_incarcare_verif_timp.sv
// Combinational time range checker.
//   i_ore    : hours   (legal 0..23)
//   i_minute : minutes (legal 0..59)
//   o_valid  : 1 when both fields are in range
module arbitru_incarcare_verif_timp
  import arbitru_incarcare_pkg::*;
(
  input  logic [ORE_W-1:0]    i_ore,
  input  logic [MINUTE_W-1:0] i_minute,
  output logic                o_valid
);

  assign o_valid = (i_ore < MAX_ORE) && (i_minute < MAX_MINUTE);

endmodule

// File: rtl/arbitru_incarcare.sv
// Arbiter granting one of two time-setting requesters access to the time counter's
// single load port.
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : arbitru_incarcare_if.slave (requests, proposed times, load/ack/err/busy)
// Parameter GUARD_CYCLES (1..15): idle cycles enforced after each grant.
// Macro ARBITRU_RR_EN: round-robin arbitration on ties; undefined gives fixed
// manual-over-UART priority.
module arbitru_incarcare
  import arbitru_incarcare_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = 2
) (
  input logic               i_clk,
  input logic               i_rst_n,
  arbitru_incarcare_if.slave bus
);

  localparam logic [3:0] GUARD_LAST = 4'(GUARD_CYCLES - 1);

  state_e              r_state;
  state_e              w_state_next;
  req_id_e             r_winner;
  req_id_e             w_winner;
  logic [ORE_W-1:0]    r_ore;
  logic [MINUTE_W-1:0] r_minute;
  logic                r_valid;
  logic [3:0]          r_guard_cnt;
  logic                w_any_req;
  logic                w_time_ok;

  assign w_any_req = bus.req_manual | bus.req_uart;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
`ifdef ARBITRU_RR_EN
  req_id_e r_rr_last;

  always_comb begin
    w_winner = ReqManual;
    if (bus.req_manual && bus.req_uart) begin
      w_winner = (r_rr_last == ReqUart) ? ReqManual : ReqUart;
    end else if (bus.req_uart) begin
      w_winner = ReqUart;
    end
  end

  // Updated on every grant, whether the captured time later proves valid or not.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rr_last <= ReqUart;
    end else if (r_state == StIdle && w_any_req) begin
      r_rr_last <= w_winner;
    end
  end
`else
  always_comb begin
    w_winner = (bus.req_uart && !bus.req_manual) ? ReqUart : ReqManual;
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (w_any_req) w_state_next = StCapture;
      StCapture: w_state_next = StLoad;
      StLoad:    w_state_next = StGuard;
      StGuard:   if (r_guard_cnt == 4'd0) w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: captured time, validity flag, guard counter
  // ---------------------------------------------------------------------------
  arbitru_incarcare_verif_timp u_verif_timp (
    .i_ore    (r_ore),
    .i_minute (r_minute),
    .o_valid  (w_time_ok)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_winner    <= ReqManual;
      r_ore       <= '0;
      r_minute    <= '0;
      r_valid     <= 1'b0;
      r_guard_cnt <= '0;
    end else begin
      // Data is sampled only at the grant edge; later input changes are ignored.
      if (r_state == StIdle && w_any_req) begin
        r_winner <= w_winner;
        if (w_winner == ReqUart) begin
          r_ore    <= bus.ore_uart;
          r_minute <= bus.minute_uart;
        end else begin
          r_ore    <= bus.ore_manual;
          r_minute <= bus.minute_manual;
        end
      end

      if (r_state == StCapture) begin
        r_valid <= w_time_ok;
      end

      // Counter preloaded on leaving LOAD so GUARD lasts exactly GUARD_CYCLES cycles.
      if (r_state == StLoad) begin
        r_guard_cnt <= GUARD_LAST;
      end else if (r_state == StGuard && r_guard_cnt != 4'd0) begin
        r_guard_cnt <= r_guard_cnt - 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  assign bus.ore_out    = r_ore;
  assign bus.minute_out = r_minute;

  always_comb begin
    bus.load       = 1'b0;
    bus.ack_manual = 1'b0;
    bus.ack_uart   = 1'b0;
    bus.err_manual = 1'b0;
    bus.err_uart   = 1'b0;
    bus.busy       = (r_state != StIdle);
    if (r_state == StLoad) begin
      if (r_valid) begin
        bus.load       = 1'b1;
        bus.ack_manual = (r_winner == ReqManual);
        bus.ack_uart   = (r_winner == ReqUart);
      end else begin
        bus.err_manual = (r_winner == ReqManual);
        bus.err_uart   = (r_winner == ReqUart);
      end
    end
  end

endmodule

// File: tb/tb_arbitru_incarcare.sv
// Self-checking bench for arbitru_incarcare: directed scenarios followed by random
// traffic, checked every cycle against a transaction-level reference model.
module tb_arbitru_incarcare;

  localparam int G = 2;

  logic clk;
  logic rst_n;

  arbitru_incarcare_if bus ();

  arbitru_incarcare #(
    .GUARD_CYCLES (G)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total;
  int n_bad;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: one operation in flight at most. m_age counts edges since grant:
  // age 1 is the load/ack/err cycle, the requester may be re-sampled 3+G edges later.
  bit m_busy;
  int m_age;
  bit m_who;      // 0 manual, 1 uart
  int m_ore;
  int m_min;
  bit m_ok;
  bit m_rr_last;

  int dut_log[$];     // valid loads seen: who*10000 + ore*100 + min
  int dut_err[$];     // errored grants seen, same encoding
  int dut_cyc[$];     // cycle numbers of the loads
  int exp_loads;
  int busy_cnt;
  int cyc;

  task automatic model_reset();
    m_busy    = 1'b0;
    m_age     = 0;
    m_rr_last = 1'b1;
  endtask

  task automatic model_edge();
    bit rm;
    bit ru;
    bit who;
    rm = bus.req_manual;
    ru = bus.req_uart;
    if (!rst_n) return;
    if (m_busy) begin
      m_age++;
      if (m_age == 2 + G) m_busy = 1'b0;
    end else if (rm || ru) begin
`ifdef ARBITRU_RR_EN
      if (rm && ru) who = ~m_rr_last;
      else          who = ru;
`else
      who = ru && !rm;
`endif
      m_busy    = 1'b1;
      m_age     = 0;
      m_who     = who;
      m_rr_last = who;
      m_ore     = who ? int'(bus.ore_uart) : int'(bus.ore_manual);
      m_min     = who ? int'(bus.minute_uart) : int'(bus.minute_manual);
      m_ok      = (m_ore < 24) && (m_min < 60);
    end
  endtask

  task automatic check_outputs();
    logic [5:0] e;
    logic [5:0] g;
    bit in_load;
    in_load = m_busy && (m_age == 1);
    e = {m_busy, in_load && m_ok,
         in_load && m_ok && !m_who, in_load && m_ok && m_who,
         in_load && !m_ok && !m_who, in_load && !m_ok && m_who};
    g = {bus.busy, bus.load, bus.ack_manual, bus.ack_uart, bus.err_manual, bus.err_uart};
    chk("ctl", 32'(g), 32'(e));
    if (m_busy && m_age <= 1) begin
      chk("ore_out", 32'(bus.ore_out), 32'(m_ore));
      chk("minute_out", 32'(bus.minute_out), 32'(m_min));
    end
    if (bus.busy) busy_cnt++;
    if (bus.load) begin
      dut_log.push_back((bus.ack_uart ? 10000 : 0) + int'(bus.ore_out) * 100
                        + int'(bus.minute_out));
      dut_cyc.push_back(cyc);
    end
    if (bus.err_manual || bus.err_uart) begin
      dut_err.push_back((bus.err_uart ? 10000 : 0) + int'(bus.ore_out) * 100
                        + int'(bus.minute_out));
    end
    if (in_load) begin
      if (m_ok) exp_loads++;
      // Requester releases its request once answered.
      if (m_who) bus.req_uart = 1'b0;
      else       bus.req_manual = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_man(input bit r, input int o, input int m);
    bus.req_manual    = r;
    bus.ore_manual    = 5'(o);
    bus.minute_manual = 6'(m);
  endtask

  task automatic set_uart(input bit r, input int o, input int m);
    bus.req_uart    = r;
    bus.ore_uart    = 5'(o);
    bus.minute_uart = 6'(m);
  endtask

  task automatic rand_time(output int o, output int m);
    case ($urandom_range(0, 9))
      0:       begin o = 23; m = 59; end
      1:       begin o = 24; m = 0;  end
      2:       begin o = 0;  m = 60; end
      3:       begin o = 0;  m = 0;  end
      4:       begin o = int'($urandom_range(0, 31)); m = int'($urandom_range(0, 63)); end
      default: begin o = int'($urandom_range(0, 23)); m = int'($urandom_range(0, 59)); end
    endcase
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int base;
    int o;
    int m;
    n_total   = 0;
    n_bad     = 0;
    cyc       = 0;
    exp_loads = 0;
    rst_n     = 1'b0;
    set_man(1'b0, 0, 0);
    set_uart(1'b0, 0, 0);
    model_reset();

    // Reset state
    @(negedge clk);
    chk("rst_ctl", 32'({bus.busy, bus.load, bus.ack_manual, bus.ack_uart,
                        bus.err_manual, bus.err_uart}), 32'd0);
    chk("rst_ore", 32'(bus.ore_out), 32'd0);
    chk("rst_minute", 32'(bus.minute_out), 32'd0);
    rst_n = 1'b1;
    run(2);

    // Single manual request 12:34
    busy_cnt = 0;
    base = dut_log.size();
    set_man(1'b1, 12, 34);
    run(3 + G + 2);
    chk("single_cnt", 32'(dut_log.size() - base), 32'd1);
    chk("single_val", 32'(dut_log[base]), 32'd1234);
    chk("single_busy", 32'(busy_cnt), 32'(2 + G));

    // Simultaneous requests, twice back-to-back, from a fresh pointer
    pulse_reset();
    base = dut_log.size();
    for (int k = 0; k < 2; k++) begin
      set_man(1'b1, 8, 15);
      set_uart(1'b1, 20, 45);
      run(2 * (3 + G) + 1);
    end
    chk("tie_cnt", 32'(dut_log.size() - base), 32'd4);
    chk("tie0", 32'(dut_log[base]), 32'd815);
    chk("tie1", 32'(dut_log[base + 1]), 32'd12045);
    chk("tie2", 32'(dut_log[base + 2]), 32'd815);
    chk("tie3", 32'(dut_log[base + 3]), 32'd12045);
    chk("tie_gap", 32'(dut_cyc[base + 1] - dut_cyc[base]), 32'(3 + G));

    // Range boundaries via UART: 24:00, 23:60 rejected, 23:59 loaded
    base = dut_log.size();
    set_uart(1'b1, 24, 0);  run(3 + G + 1);
    set_uart(1'b1, 23, 60); run(3 + G + 1);
    set_uart(1'b1, 23, 59); run(3 + G + 1);
    chk("err_cnt", 32'(dut_err.size()), 32'd2);
    chk("err0", 32'(dut_err[0]), 32'd12400);
    chk("err1", 32'(dut_err[1]), 32'd12360);
    chk("b2359", 32'(dut_log[base]), 32'd12359);
    set_man(1'b1, 0, 0); run(3 + G + 1);
    chk("b0000", 32'(dut_log[base + 1]), 32'd0);

    // Data inputs change after the grant
    base = dut_log.size();
    set_man(1'b1, 5, 5);
    step();
    step();
    bus.ore_manual    = 5'd6;
    bus.minute_manual = 6'd6;
    run(3 + G);
    chk("hold_val", 32'(dut_log[base]), 32'd505);

    // Short-lived UART request while busy is never sampled
    base = dut_log.size();
    set_man(1'b1, 1, 2);
    step();
    set_uart(1'b1, 3, 4);
    run(2);
    bus.req_uart = 1'b0;
    run(3 + G + 2);
    chk("drop_cnt", 32'(dut_log.size() - base), 32'd1);
    chk("drop_val", 32'(dut_log[base]), 32'd102);

    // Reset during CAPTURE aborts; held request is served after release
    base = dut_log.size();
    set_man(1'b1, 10, 10);
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("abort_ctl", 32'({bus.busy, bus.load, bus.ack_manual, bus.ack_uart,
                          bus.err_manual, bus.err_uart}), 32'd0);
    chk("abort_ore", 32'(bus.ore_out), 32'd0);
    run(2);
    rst_n = 1'b1;
    run(3 + G + 2);
    chk("abort_cnt", 32'(dut_log.size() - base), 32'd1);
    chk("abort_val", 32'(dut_log[base]), 32'd1010);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (!bus.req_manual && $urandom_range(0, 3) == 0) begin
        rand_time(o, m);
        set_man(1'b1, o, m);
      end else if (bus.req_manual && m_busy && !m_who && $urandom_range(0, 1) == 0) begin
        bus.ore_manual    = 5'($urandom);
        bus.minute_manual = 6'($urandom);
      end
      if (!bus.req_uart && $urandom_range(0, 3) == 0) begin
        rand_time(o, m);
        set_uart(1'b1, o, m);
      end else if (bus.req_uart && m_busy && m_who && $urandom_range(0, 1) == 0) begin
        bus.ore_uart    = 5'($urandom);
        bus.minute_uart = 6'($urandom);
      end
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      step();
    end
    chk("load_total", 32'(dut_log.size()), 32'(exp_loads));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
